// File: rtl/servo_pulse_decoder.sv
// Two-channel servo pulse decoder: measures left/right high time in 0.1 % units and maps the pair to a direction code.
// Duty updates 3 clk after the closing rising edge; dir_valid follows one clk after the later channel publishes.

module servo_pulse_channel #(
  parameter int CLK_PER_UNIT  = 1000,
  parameter int TIMEOUT_UNITS = 1200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm,
  output logic [9:0] duty,
  output logic       pub,
  output logic       lost
);

  localparam int PW = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
  localparam int TW = $clog2(TIMEOUT_UNITS + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_UNIT - 1);
  localparam logic [TW-1:0] TO_VAL  = TW'(TIMEOUT_UNITS);

  typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    high_q, high_d;
  logic [9:0]    width_q, width_d;
  logic [9:0]    duty_q, duty_d;
  logic [TW-1:0] period_q, period_d;
  logic          pub_q, pub_d;
  logic          lost_q, lost_d;

  logic          rise, fall, wrap;
  logic [9:0]    high_inc;
  logic [TW-1:0] period_inc;

  always_comb begin
    sync_d     = {sync_q[0], pwm};
    prev_d     = sync_q[1];
    rise       = sync_q[1] & ~prev_q;
    fall       = ~sync_q[1] & prev_q;
    wrap       = (presc_q == PRE_MAX);
    // The falling-edge cycle itself is counted, so width = floor(high cycles / CLK_PER_UNIT).
    high_inc   = (wrap && (high_q != 10'h3FF)) ? high_q + 10'd1 : high_q;
    period_inc = wrap ? period_q + TW'(1) : period_q;

    state_d  = state_q;
    presc_d  = presc_q;
    high_d   = high_q;
    period_d = period_q;
    width_d  = width_q;
    duty_d   = duty_q;
    pub_d    = 1'b0;
    lost_d   = lost_q;

    case (state_q)
      WAIT_RISE: begin
        if (rise) begin
          state_d  = HIGH;
          presc_d  = '0;
          high_d   = '0;
          period_d = '0;
        end
      end
      HIGH, LOW: begin
        presc_d  = wrap ? '0 : presc_q + PW'(1);
        period_d = period_inc;
        if (state_q == HIGH) begin
          high_d = high_inc;
        end
        if ((state_q == HIGH) && fall) begin
          width_d = high_inc;
          state_d = LOW;
        end
        if ((state_q == LOW) && rise) begin
          duty_d   = width_q;
          pub_d    = 1'b1;
          lost_d   = 1'b0;
          presc_d  = '0;
          high_d   = '0;
          period_d = '0;
          state_d  = HIGH;
        end else if (period_inc == TO_VAL) begin
          lost_d  = 1'b1;
          state_d = WAIT_RISE;
        end
      end
      default: state_d = WAIT_RISE;
    endcase
  end

  // Synchroniser and edge history reset high so a line already high at release is not taken as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_RISE;
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      presc_q  <= '0;
      high_q   <= '0;
      width_q  <= '0;
      duty_q   <= '0;
      period_q <= '0;
      pub_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      presc_q  <= presc_d;
      high_q   <= high_d;
      width_q  <= width_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      pub_q    <= pub_d;
      lost_q   <= lost_d;
    end
  end

  assign duty = duty_q;
  assign pub  = pub_q;
  assign lost = lost_q;

endmodule

module servo_pulse_decoder #(
  parameter int CLK_PER_UNIT  = 1000,
  parameter int TIMEOUT_UNITS = 1200,
  parameter int TOL           = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       left_pwm,
  input  logic       right_pwm,
  output logic [9:0] left_duty,
  output logic [9:0] right_duty,
  output logic [2:0] direction,
  output logic       dir_valid,
  output logic       dir_error,
  output logic       signal_lost
);

  logic pub_l, pub_r, lost_l, lost_r;

  servo_pulse_channel #(.CLK_PER_UNIT(CLK_PER_UNIT), .TIMEOUT_UNITS(TIMEOUT_UNITS)) u_left (
    .clk(clk), .rst_n(resetn), .pwm(left_pwm), .duty(left_duty), .pub(pub_l), .lost(lost_l)
  );

  servo_pulse_channel #(.CLK_PER_UNIT(CLK_PER_UNIT), .TIMEOUT_UNITS(TIMEOUT_UNITS)) u_right (
    .clk(clk), .rst_n(resetn), .pwm(right_pwm), .duty(right_duty), .pub(pub_r), .lost(lost_r)
  );

  logic       fresh_l_q, fresh_l_d;
  logic       fresh_r_q, fresh_r_d;
  logic [2:0] direction_q, direction_d;
  logic       dir_valid_q, dir_valid_d;
  logic       dir_error_q, dir_error_d;
  logic       signal_lost_q, signal_lost_d;
  logic       fl, fr, hit;
  logic [2:0] code;

  function automatic logic near(input logic [9:0] v, input int target);
    return (int'(v) >= target - TOL) && (int'(v) <= target + TOL);
  endfunction

  always_comb begin
    hit  = 1'b1;
    code = 3'b000;
    if      (near(left_duty, 75) && near(right_duty, 28)) code = 3'b000;
    else if (near(left_duty, 82) && near(right_duty, 20)) code = 3'b001;
    else if (near(left_duty, 66) && near(right_duty, 36)) code = 3'b010;
    else if (near(left_duty, 82) && near(right_duty, 36)) code = 3'b011;
    else if (near(left_duty, 66) && near(right_duty, 20)) code = 3'b100;
    else hit = 1'b0;

    // A publish this cycle counts as fresh, so pairing costs only one clk after the later channel.
    fl = fresh_l_q | pub_l;
    fr = fresh_r_q | pub_r;

    fresh_l_d     = fl;
    fresh_r_d     = fr;
    direction_d   = direction_q;
    dir_valid_d   = 1'b0;
    dir_error_d   = dir_error_q;
    signal_lost_d = lost_l | lost_r;

    if (signal_lost_q) begin
      fresh_l_d   = 1'b0;
      fresh_r_d   = 1'b0;
      direction_d = 3'b000;
    end else if (fl && fr) begin
      fresh_l_d   = 1'b0;
      fresh_r_d   = 1'b0;
      dir_valid_d = 1'b1;
      direction_d = hit ? code : 3'b000;
      dir_error_d = ~hit;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fresh_l_q     <= 1'b0;
      fresh_r_q     <= 1'b0;
      direction_q   <= 3'b000;
      dir_valid_q   <= 1'b0;
      dir_error_q   <= 1'b0;
      signal_lost_q <= 1'b0;
    end else begin
      fresh_l_q     <= fresh_l_d;
      fresh_r_q     <= fresh_r_d;
      direction_q   <= direction_d;
      dir_valid_q   <= dir_valid_d;
      dir_error_q   <= dir_error_d;
      signal_lost_q <= signal_lost_d;
    end
  end

  assign direction   = direction_q;
  assign dir_valid   = dir_valid_q;
  assign dir_error   = dir_error_q;
  assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Bench for servo_pulse_decoder with CLK_PER_UNIT = 10; most frames are 1000 clk since duty is
// measured in units and frame length only matters for the timeout scenarios.
module tb_servo_pulse_decoder;

  localparam int CPU = 10;
  localparam int PER = 1000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       left_pwm = 1'b0;
  logic       right_pwm = 1'b0;
  logic [9:0] left_duty, right_duty;
  logic [2:0] direction;
  logic       dir_valid, dir_error, signal_lost;

  servo_pulse_decoder #(.CLK_PER_UNIT(CPU), .TIMEOUT_UNITS(1200), .TOL(2)) dut (
    .clk(clk), .resetn(resetn), .left_pwm(left_pwm), .right_pwm(right_pwm),
    .left_duty(left_duty), .right_duty(right_duty), .direction(direction),
    .dir_valid(dir_valid), .dir_error(dir_error), .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int cap_cyc = 0;
  logic [2:0] cap_dir = 3'b000;
  logic       cap_err = 1'b0;
  logic [9:0] cap_l = '0;
  logic [9:0] cap_r = '0;

  int tab_l [5] = '{75, 82, 66, 82, 66};
  int tab_r [5] = '{28, 20, 36, 36, 20};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dir_valid === 1'b1) begin
      dv_cnt++;
      cap_cyc = cyc;
      cap_dir = direction;
      cap_err = dir_error;
      cap_l   = left_duty;
      cap_r   = right_duty;
    end
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int model_duty(input int hi_cycles);
    int u;
    u = hi_cycles / CPU;
    if (u > 1023) u = 1023;
    return u;
  endfunction

  // Returns {error, code}.
  function automatic logic [3:0] model_decode(input int l, input int r);
    for (int i = 0; i < 5; i++) begin
      if (iabs(l - tab_l[i]) <= 2 && iabs(r - tab_r[i]) <= 2) return {1'b0, 3'(i)};
    end
    return 4'b1000;
  endfunction

  task automatic drive_chan(input int ch, input int hi, input int off, input int per, input int n);
    for (int k = 0; k < n; k++) begin
      if (ch == 0) left_pwm = 1'b0; else right_pwm = 1'b0;
      repeat (off) @(negedge clk);
      if (ch == 0) left_pwm = 1'b1; else right_pwm = 1'b1;
      repeat (hi) @(negedge clk);
      if (ch == 0) left_pwm = 1'b0; else right_pwm = 1'b0;
      repeat (per - off - hi) @(negedge clk);
    end
  endtask

  task automatic run_pair(input int hl, input int hr, input int off_r, input int per, input int n);
    fork
      drive_chan(0, hl, 0, per, n);
      drive_chan(1, hr, off_r, per, n);
    join
  endtask

  task automatic test_reset;
    int t0, dv0;
    resetn = 1'b0;
    @(negedge clk);
    fork
      run_pair(820, 200, 0, PER, 4);
      begin
        repeat (100) @(negedge clk);
        checks++; if (left_duty !== 10'd0 || right_duty !== 10'd0) begin
          errs++; $display("FAIL reset_duty: got %0d/%0d, expected 0/0", left_duty, right_duty); end
        checks++; if (direction !== 3'd0) begin
          errs++; $display("FAIL reset_direction: got %0d, expected 0", direction); end
        checks++; if ({dir_valid, dir_error, signal_lost} !== 3'b000) begin
          errs++; $display("FAIL reset_flags: got %b, expected 000", {dir_valid, dir_error, signal_lost}); end
        // Release while the left line is 400 clk into a high pulse.
        repeat (1300) @(negedge clk);
        resetn = 1'b1;
        t0 = cyc;
        dv0 = dv_cnt;
        for (int i = 0; i < 3000 && dv_cnt == dv0; i++) @(negedge clk);
        checks++;
        if (dv_cnt == dv0) begin
          errs++; $display("FAIL reset_first_valid: got no dir_valid, expected one within 3000 clk");
        end else if (cap_cyc - t0 < 1600 || cap_cyc - t0 > 1610) begin
          errs++; $display("FAIL reset_first_valid: got %0d clk after release, expected 1600..1610", cap_cyc - t0);
        end
        checks++; if (cap_l !== 10'd82 || cap_r !== 10'd20) begin
          errs++; $display("FAIL reset_first_duty: got %0d/%0d, expected 82/20", cap_l, cap_r); end
      end
    join
  endtask

  task automatic test_forward;
    int dv0;
    dv0 = dv_cnt;
    run_pair(820, 200, 0, PER, 3);
    checks++; if (dv_cnt - dv0 != 3) begin
      errs++; $display("FAIL fwd_valid_count: got %0d, expected 3", dv_cnt - dv0); end
    checks++; if (cap_l !== 10'd82 || cap_r !== 10'd20) begin
      errs++; $display("FAIL fwd_duty: got %0d/%0d, expected 82/20", cap_l, cap_r); end
    checks++; if (cap_dir !== 3'b001 || cap_err !== 1'b0) begin
      errs++; $display("FAIL fwd_decode: got dir=%0d err=%0d, expected dir=1 err=0", cap_dir, cap_err); end
  endtask

  task automatic test_table;
    int hl [8];
    int hr [8];
    logic [3:0] exp;
    hl = '{750, 820, 660, 820, 660, 840, 850, 829};
    hr = '{280, 200, 360, 360, 200, 200, 200, 200};
    for (int i = 0; i < 8; i++) begin
      run_pair(hl[i], hr[i], 0, PER, 2);
      exp = model_decode(model_duty(hl[i]), model_duty(hr[i]));
      checks++; if (int'(cap_l) != model_duty(hl[i]) || int'(cap_r) != model_duty(hr[i])) begin
        errs++; $display("FAIL table%0d_duty: got %0d/%0d, expected %0d/%0d", i, cap_l, cap_r,
                         model_duty(hl[i]), model_duty(hr[i])); end
      checks++; if ({cap_err, cap_dir} !== exp) begin
        errs++; $display("FAIL table%0d_decode: got err=%0d dir=%0d, expected err=%0d dir=%0d", i,
                         cap_err, cap_dir, exp[3], exp[2:0]); end
    end
  endtask

  task automatic test_saturation;
    run_pair(10240, 200, 0, 10300, 1);
    run_pair(820, 200, 0, PER, 1);
    checks++; if (int'(cap_l) != model_duty(10240)) begin
      errs++; $display("FAIL sat_duty: got %0d, expected %0d", cap_l, model_duty(10240)); end
    checks++; if (cap_err !== 1'b1 || cap_dir !== 3'b000) begin
      errs++; $display("FAIL sat_decode: got err=%0d dir=%0d, expected err=1 dir=0", cap_err, cap_dir); end
  endtask

  task automatic test_latency;
    run_pair(820, 200, 0, PER, 2);
    run_pair(660, 360, 0, PER, 1);
    left_pwm = 1'b1;
    right_pwm = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (left_duty !== 10'd82) begin
      errs++; $display("FAIL lat_clk2: got %0d, expected 82", left_duty); end
    @(posedge clk); #1;
    checks++; if (left_duty !== 10'd66 || right_duty !== 10'd36 || dir_valid !== 1'b0) begin
      errs++; $display("FAIL lat_clk3: got %0d/%0d v=%0d, expected 66/36 v=0", left_duty, right_duty, dir_valid); end
    @(posedge clk); #1;
    checks++; if (dir_valid !== 1'b1 || direction !== 3'b010) begin
      errs++; $display("FAIL lat_clk4: got v=%0d dir=%0d, expected v=1 dir=2", dir_valid, direction); end
    @(posedge clk); #1;
    checks++; if (dir_valid !== 1'b0) begin
      errs++; $display("FAIL lat_strobe_width: got %0d, expected 0", dir_valid); end
    @(negedge clk);
    run_pair(660, 360, 0, PER, 1);
  endtask

  task automatic test_timeout;
    int dv0, dv2;
    run_pair(820, 360, 0, PER, 2);
    checks++; if (cap_dir !== 3'b011) begin
      errs++; $display("FAIL to_pre_decode: got %0d, expected 3", cap_dir); end
    dv0 = dv_cnt;
    // Right line last rose 1000 clk before this window; lost is due at 12000 clk after that rise.
    fork
      drive_chan(0, 820, 0, PER, 12);
      begin
        right_pwm = 1'b0;
        repeat (10950) @(negedge clk);
        checks++; if (signal_lost !== 1'b0) begin
          errs++; $display("FAIL to_early: got %0d, expected 0", signal_lost); end
        repeat (100) @(negedge clk);
        checks++; if (signal_lost !== 1'b1) begin
          errs++; $display("FAIL to_lost: got %0d, expected 1", signal_lost); end
      end
    join
    checks++; if (direction !== 3'b000 || signal_lost !== 1'b1) begin
      errs++; $display("FAIL to_forced: got dir=%0d lost=%0d, expected dir=0 lost=1", direction, signal_lost); end
    checks++; if (dv_cnt != dv0) begin
      errs++; $display("FAIL to_no_valid: got %0d strobes, expected 0", dv_cnt - dv0); end
    dv2 = 0;
    fork
      run_pair(820, 360, 0, PER, 4);
      begin
        repeat (990) @(negedge clk);
        checks++; if (signal_lost !== 1'b1) begin
          errs++; $display("FAIL resume_still_lost: got %0d, expected 1", signal_lost); end
        repeat (20) @(negedge clk);
        checks++; if (signal_lost !== 1'b0) begin
          errs++; $display("FAIL resume_cleared: got %0d, expected 0", signal_lost); end
        dv2 = dv_cnt;
      end
    join
    checks++; if (dv_cnt - dv2 != 2 || cap_dir !== 3'b011) begin
      errs++; $display("FAIL resume_valid: got %0d strobes dir=%0d, expected 2 dir=3", dv_cnt - dv2, cap_dir); end
  endtask

  task automatic test_simultaneous;
    int dv0;
    dv0 = dv_cnt;
    run_pair(750, 280, 0, PER, 3);
    checks++; if (dv_cnt - dv0 != 3) begin
      errs++; $display("FAIL simul_count: got %0d, expected 3", dv_cnt - dv0); end
    checks++; if (cap_dir !== 3'b000 || cap_err !== 1'b0) begin
      errs++; $display("FAIL simul_decode: got dir=%0d err=%0d, expected 0/0", cap_dir, cap_err); end
  endtask

  task automatic test_skew;
    int dv0, c0;
    dv0 = dv_cnt;
    c0 = cyc;
    run_pair(820, 200, 300, PER, 3);
    checks++; if (dv_cnt - dv0 != 3) begin
      errs++; $display("FAIL skew_count: got %0d, expected 3", dv_cnt - dv0); end
    checks++; if (cap_cyc - c0 != 2304) begin
      errs++; $display("FAIL skew_timing: got %0d, expected 2304", cap_cyc - c0); end
    checks++; if (cap_dir !== 3'b001) begin
      errs++; $display("FAIL skew_decode: got %0d, expected 1", cap_dir); end
  endtask

  task automatic test_random;
    int hl, hr, e;
    logic [3:0] exp;
    for (int it = 0; it < 5; it++) begin
      e  = int'($urandom_range(0, 4));
      hl = tab_l[e] * CPU + int'($urandom_range(0, 60)) - 30;
      hr = tab_r[e] * CPU + int'($urandom_range(0, 60)) - 30;
      run_pair(hl, hr, 0, PER, 2);
      exp = model_decode(model_duty(hl), model_duty(hr));
      checks++; if (int'(cap_l) != model_duty(hl) || int'(cap_r) != model_duty(hr)) begin
        errs++; $display("FAIL rand%0d_duty: got %0d/%0d, expected %0d/%0d", it, cap_l, cap_r,
                         model_duty(hl), model_duty(hr)); end
      checks++; if ({cap_err, cap_dir} !== exp) begin
        errs++; $display("FAIL rand%0d_decode: got err=%0d dir=%0d, expected err=%0d dir=%0d", it,
                         cap_err, cap_dir, exp[3], exp[2:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_table();
    test_saturation();
    test_latency();
    test_timeout();
    test_simultaneous();
    test_skew();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
